// File: rtl/trigger_detector_pkg.sv
// Shared oscilloscope types: trigger FSM state and default sample width.
// Also provides the holdoff counter width helper.
package trigger_detector_pkg;

    localparam int DATA_BITS_DEFAULT = 12;

    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } trig_state_t;

    function automatic int cnt_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/trigger_detector_if.sv
// ADC-side sample stream in, measurement-side sample stream out.
interface trigger_detector_if
    import trigger_detector_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) ();

    logic                        adcReady;
    logic signed [DATA_BITS-1:0] adcData;
    logic signed [DATA_BITS-1:0] triggerLevel;
    logic                        risingEdge;
    logic                        dataReady;
    logic signed [DATA_BITS-1:0] dataOut;
    logic                        isTrigger;

    modport master (
        output adcReady, adcData, triggerLevel, risingEdge,
        input  dataReady, dataOut, isTrigger
    );

    modport slave (
        input  adcReady, adcData, triggerLevel, risingEdge,
        output dataReady, dataOut, isTrigger
    );

endinterface

// File: rtl/trigger_detector.sv
// Registers ADC samples and flags the sample that crosses the trigger
// level on the selected slope, with hysteresis arming and holdoff.
module trigger_detector
    import trigger_detector_pkg::*;
#(
    parameter int DATA_BITS       = DATA_BITS_DEFAULT,
    parameter int HYSTERESIS      = 16,
    parameter int HOLDOFF_SAMPLES = 64
) (
    input logic         clock,
    input logic         reset,
    trigger_detector_if.slave bus
);

    localparam int W  = DATA_BITS + 1;
    localparam int CW = cnt_bits(HOLDOFF_SAMPLES);
    localparam logic [CW-1:0]       HOLD_INIT = CW'(HOLDOFF_SAMPLES);
    localparam logic signed [W-1:0] HYST      = W'(HYSTERESIS);

    // One extra bit keeps level +/- HYST from wrapping at the rails.
    logic signed [W-1:0] sample;
    logic signed [W-1:0] level;
    logic signed [W-1:0] armLow;
    logic signed [W-1:0] armHigh;

    assign sample  = {bus.adcData[DATA_BITS-1], bus.adcData};
    assign level   = {bus.triggerLevel[DATA_BITS-1], bus.triggerLevel};
    assign armLow  = level - HYST;
    assign armHigh = level + HYST;

    trig_state_t   state;
    trig_state_t   stateNext;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic          slope;
    logic          slopeChange;
    logic          armHit;
    logic          crossHit;
    logic          fire;

    logic                        readyQ;
    logic signed [DATA_BITS-1:0] dataQ;
    logic                        trigQ;

    assign slopeChange = bus.adcReady && (bus.risingEdge != slope);
    assign armHit   = slope ? (sample < armLow) : (sample > armHigh);
    assign crossHit = slope ? (sample >= level) : (sample <= level);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARMING;
            count <= '0;
            slope <= bus.risingEdge;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (bus.adcReady) begin
                slope <= bus.risingEdge;
            end
        end
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        if (bus.adcReady) begin
            if (slopeChange) begin
                stateNext = ARMING;
                countNext = '0;
            end else begin
                unique case (state)
                    ARMING: begin
                        if (armHit) begin
                            stateNext = ARMED;
                        end
                    end
                    ARMED: begin
                        if (crossHit) begin
                            if (HOLDOFF_SAMPLES == 0) begin
                                stateNext = ARMING;
                            end else begin
                                stateNext = HOLDOFF;
                                countNext = HOLD_INIT;
                            end
                        end
                    end
                    HOLDOFF: begin
                        countNext = (count == '0) ? '0 : count - CW'(1);
                        if (count <= CW'(1)) begin
                            stateNext = ARMING;
                        end
                    end
                    default: begin
                        stateNext = ARMING;
                        countNext = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        fire = bus.adcReady && !slopeChange
            && (state == ARMED) && crossHit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readyQ <= 1'b0;
            dataQ  <= '0;
            trigQ  <= 1'b0;
        end else begin
            readyQ <= bus.adcReady;
            trigQ  <= fire;
            if (bus.adcReady) begin
                dataQ <= bus.adcData;
            end
        end
    end

    assign bus.dataReady = readyQ;
    assign bus.dataOut   = dataQ;
    assign bus.isTrigger = trigQ;

endmodule

// File: doc/trigger_detector.md
Name: trigger_detector

Overview:
- Sits between the ADC sample interface and the signal-measurement and display path.
- Produces the sample stream (dataReady, dataOut, isTrigger) that the measurement block consumes.
- Registers each ADC sample and detects a level crossing on the selected slope, with hysteresis and holdoff.
- Flags the crossing sample with a one-cycle isTrigger aligned to that sample's dataReady.

Parameters:
- DATA_BITS, 12: sample width, signed two's complement.
- HYSTERESIS, 16: arming margin in LSBs; unsigned; must be less than 2^(DATA_BITS-1).
- HOLDOFF_SAMPLES, 64: number of accepted samples ignored after a trigger; 0 disables holdoff.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- adcReady  in  1  one-cycle strobe; adcData is valid this cycle.
- adcData  in  DATA_BITS  signed ADC sample.
- triggerLevel  in  DATA_BITS  signed trigger threshold; sampled on every adcReady.
- risingEdge  in  1  1 = trigger on a rising crossing, 0 = trigger on a falling crossing.
- dataReady  out  1  one-cycle strobe; dataOut is valid this cycle.
- dataOut  out  DATA_BITS  signed registered copy of adcData.
- isTrigger  out  1  high only in a cycle where dataReady is high, marking the trigger sample.

Behaviour:
- Reset (synchronous, active-high):
  - dataReady=0, dataOut=0, isTrigger=0.
  - state=ARMING, holdoff counter=0, stored slope=risingEdge.
  - Reset overrides a coincident adcReady; that sample is dropped.
- Latency: exactly 1 clock.
  - adcReady at cycle N gives dataReady=1, dataOut=adcData, and isTrigger (if firing) at cycle N+1.
  - With no adcReady, dataReady=0 and isTrigger=0 the next cycle; dataOut holds its value.
- Arithmetic:
  - Sign-extend adcData and triggerLevel to DATA_BITS+1.
  - Compute armLow = level - HYSTERESIS and armHigh = level + HYSTERESIS at DATA_BITS+1 width. No saturation, no wrap.
  - All comparisons are signed at DATA_BITS+1 width.
- FSM (advances only on adcReady):
  - ARMING:
    - Rising: sample < armLow -> ARMED.
    - Falling: sample > armHigh -> ARMED.
    - Otherwise stay in ARMING.
  - ARMED:
    - Rising: sample >= level -> fire.
    - Falling: sample <= level -> fire.
    - On fire: isTrigger=1 on this sample's output; go to HOLDOFF with counter=HOLDOFF_SAMPLES, or to ARMING if HOLDOFF_SAMPLES=0.
  - HOLDOFF:
    - Each accepted sample decrements the counter; crossings are ignored.
    - When the counter reaches 0 (processing the sample that takes it 1->0), go to ARMING.
    - That sample is not evaluated for arming.
- A sample that arms the FSM can never also fire. The next sample is the earliest possible trigger.
- Slope change:
  - When risingEdge differs from the stored slope on an adcReady, store the new slope and force ARMING. No trigger on that sample.
  - Holdoff is abandoned.
- A triggerLevel change takes effect on the next adcReady. The current state is kept.
- At most one trigger per crossing. A signal parked at or beyond the level never retriggers until it re-arms through the hysteresis band.
- Back-to-back adcReady (every cycle) is supported at full rate.

Decomposition:
- Shared oscilloscope package:
  - trigger FSM state typedef (ARMING, ARMED, HOLDOFF; 2-bit encoding).
  - default DATA_BITS constant.
- Holdoff counter width: clog2(HOLDOFF_SAMPLES+1), minimum 1.
- No sub-module. The compare logic, FSM and holdoff counter stay in one module; the expected size is about 150 lines.

Test Plan:
- Rising, level=0, HYST=16, HOLDOFF=4, samples -100, -20, 5, 50: arms on -100, fires on 5. isTrigger on the 3rd dataReady only, 1 clock after the adcReady for 5.
- Same setup, samples -100, 5, -100, 5, -100, 5: the trigger at the first 5 starts holdoff of 4 samples. The next trigger is on the 4th 5, after re-arming at -100.
- Noise at the threshold, level=0, HYST=16, sine of ±10 around 0: after an initial arm at -100 and one trigger, no further isTrigger while the noise stays inside ±16.
- Falling, level=500, samples 600, 520, 500: arms on 600, fires on 500. Then switch risingEdge to 1 mid-stream with a sample of -600: no trigger on that sample, and the FSM is in ARMING with the new slope.
- Extremes, DATA_BITS=12, level=-2040, HYST=16: armLow=-2056 is unreachable, so never arms and never triggers. Level=2047 falling: armHigh=2063 is unreachable, so no trigger. No wrap-around false triggers.
- Reset asserted in the same cycle as adcReady while ARMED: the next cycle has dataReady=0, isTrigger=0, dataOut=0. The following crossing sample does not fire until the FSM re-arms.
